// File: rtl/cpu_core_if.sv
// Shared memory bus between cpu_core and the memory/ROM model.
// The core is the master; memory answers data_in with zero wait states.
interface cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              we;
  logic              sync;

  modport master (
    output addr,
    output data_out,
    output we,
    output sync,
    input  data_in
  );

  modport slave (
    input  addr,
    input  data_out,
    input  we,
    input  sync,
    output data_in
  );
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle 6502-subset core: fetch/decode/execute sequencer
// owning PC, A, X and status, driving one shared memory bus.
module cpu_core #(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 'h0200
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_core_if.master        bus,
  output logic              halted,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] x_o,
  output logic [7:0]        status_o,
  output logic [ADDR_W-1:0] pc_o
);

  if (DATA_W < 8 || ADDR_W > 2 * DATA_W) begin : g_bad_params
    $error("cpu_core: need DATA_W >= 8 and ADDR_W <= 2*DATA_W");
  end

  localparam int MSB = DATA_W - 1;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_LDX = 8'hA2;
  localparam logic [7:0] OP_ADC = 8'h69;
  localparam logic [7:0] OP_CLC = 8'h18;
  localparam logic [7:0] OP_SEC = 8'h38;
  localparam logic [7:0] OP_INX = 8'hE8;
  localparam logic [7:0] OP_TAX = 8'hAA;
  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_JMP = 8'h4C;
  localparam logic [7:0] OP_STA = 8'h8D;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_OPND,
    S_ADDR_LO,
    S_ADDR_HI,
    S_WRITE,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              v_q, v_d;
  logic              n_q, n_d;
  logic [7:0]        op_q, op_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] ea_q, ea_d;

  logic [7:0]          opc;
  logic                is_impl;
  logic                is_imm;
  logic                is_abs;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] tgt_w;
  logic [ADDR_W-1:0]   tgt;
  logic [DATA_W-1:0]   res;

  // Only the low byte carries the opcode; wider data bits are ignored.
  assign opc     = bus.data_in[7:0];
  assign is_impl = opc inside {OP_CLC, OP_SEC, OP_INX, OP_TAX, OP_NOP};
  assign is_imm  = opc inside {OP_LDA, OP_LDX, OP_ADC};
  assign is_abs  = opc inside {OP_JMP, OP_STA};

  assign pc_inc = pc_q + ADDR_W'(1);
  assign sum    = {1'b0, acc_q} + {1'b0, bus.data_in}
                + {{DATA_W{1'b0}}, c_q};
  assign tgt_w  = {bus.data_in, lo_q};
  assign tgt    = tgt_w[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RST_PC;
      acc_q   <= '0;
      x_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      op_q    <= '0;
      lo_q    <= '0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      ea_q    <= ea_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    x_d     = x_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    op_d    = op_q;
    lo_d    = lo_q;
    ea_d    = ea_q;
    res     = '0;
    unique case (state_q)
      S_FETCH: begin
        op_d = opc;
        pc_d = pc_inc;
        unique case (1'b1)
          is_impl: state_d = S_EXEC;
          is_imm:  state_d = S_OPND;
          is_abs:  state_d = S_ADDR_LO;
          default: state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (1'b1)
          op_q == OP_CLC: c_d = 1'b0;
          op_q == OP_SEC: c_d = 1'b1;
          op_q == OP_INX: begin
            res = x_q + DATA_W'(1);
            x_d = res;
            n_d = res[MSB];
            z_d = ~|res;
          end
          op_q == OP_TAX: begin
            res = acc_q;
            x_d = res;
            n_d = res[MSB];
            z_d = ~|res;
          end
          default: ;
        endcase
      end
      S_OPND: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (1'b1)
          op_q == OP_LDA: begin
            res   = bus.data_in;
            acc_d = res;
          end
          op_q == OP_LDX: begin
            res = bus.data_in;
            x_d = res;
          end
          default: begin
            res   = sum[MSB:0];
            acc_d = res;
            c_d   = sum[DATA_W];
            v_d   = (acc_q[MSB] == bus.data_in[MSB])
                 && (res[MSB] != acc_q[MSB]);
          end
        endcase
        n_d = res[MSB];
        z_d = ~|res;
      end
      S_ADDR_LO: begin
        state_d = S_ADDR_HI;
        lo_d    = bus.data_in;
        pc_d    = pc_inc;
      end
      S_ADDR_HI: begin
        if (op_q == OP_JMP) begin
          state_d = S_FETCH;
          pc_d    = tgt;
        end else begin
          state_d = S_WRITE;
          ea_d    = tgt;
          pc_d    = pc_inc;
        end
      end
      S_WRITE: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Reset low kills the strobe at once so an in-flight store is dropped.
  always_comb begin
    bus.addr     = pc_q;
    bus.data_out = '0;
    bus.we       = 1'b0;
    bus.sync     = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      S_FETCH: bus.sync = 1'b1;
      S_WRITE: begin
        bus.addr     = ea_q;
        bus.data_out = acc_q;
        bus.we       = rst_n;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign acc_o    = acc_q;
  assign x_o      = x_q;
  assign status_o = {n_q, v_q, 4'b0000, z_q, c_q};
  assign pc_o     = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: instruction-level model predicts every bus cycle,
// plus directed programs with hand-computed expectations.
module tb_cpu_core;

  logic clk;
  logic rst_n;

  cpu_core_if #(.DATA_W(8), .ADDR_W(16)) bus ();
  cpu_core_if #(.DATA_W(8), .ADDR_W(16)) bus2 ();

  logic        halted, halted2;
  logic [7:0]  acc, x, st, acc2, x2, st2;
  logic [15:0] pc, pc2;

  logic [7:0] mem  [0:65535];
  logic [7:0] mem2 [0:65535];
  logic [7:0] mmem [0:65535];

  cpu_core #(.DATA_W(8), .ADDR_W(16), .RESET_PC('h0200)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted),
    .acc_o(acc), .x_o(x), .status_o(st), .pc_o(pc)
  );

  cpu_core #(.DATA_W(8), .ADDR_W(16), .RESET_PC('hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .halted(halted2),
    .acc_o(acc2), .x_o(x2), .status_o(st2), .pc_o(pc2)
  );

  assign bus.data_in  = mem[bus.addr];
  assign bus2.data_in = mem2[bus2.addr];

  always @(posedge clk) if (bus.we) mem[bus.addr] <= bus.data_out;
  always @(posedge clk) if (bus2.we) mem2[bus2.addr] <= bus2.data_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    logic [15:0] addr;
    logic        sync;
    logic        we;
    logic        hlt;
    logic [7:0]  dout;
    logic [15:0] pc;
    logic        regs;
    logic [7:0]  acc;
    logic [7:0]  x;
    logic [7:0]  st;
  } cyc_t;

  cyc_t        q[$];
  logic [15:0] m_pc;
  logic [7:0]  m_acc, m_x;
  logic        m_c, m_z, m_v, m_n, m_halt;

  function automatic logic [7:0] m_st();
    return {m_n, m_v, 4'b0000, m_z, m_c};
  endfunction

  task automatic push(input logic [15:0] a, input logic s, input logic w,
                      input logic h, input logic [7:0] d,
                      input logic [15:0] p, input logic r);
    cyc_t e;
    e.addr = a; e.sync = s; e.we = w; e.hlt = h; e.dout = d;
    e.pc = p; e.regs = r; e.acc = m_acc; e.x = m_x; e.st = m_st();
    q.push_back(e);
  endtask

  task automatic set_nz(input logic [7:0] v);
    m_n = (v >= 8'd128);
    m_z = (v == 8'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 16'h0200; m_acc = 0; m_x = 0;
    m_c = 0; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
  endtask

  task automatic model_step();
    logic [7:0]  op, imm;
    logic [15:0] p1, p2, t;
    int          s, sa, si;
    if (m_halt) begin
      push(m_pc, 0, 0, 1, 8'h00, m_pc, 1);
      return;
    end
    op = mmem[m_pc];
    push(m_pc, 1, 0, 0, 8'h00, m_pc, 1);
    p1  = m_pc + 16'd1;
    p2  = p1 + 16'd1;
    imm = mmem[p1];
    case (op)
      8'h18, 8'h38, 8'hE8, 8'hAA, 8'hEA: begin
        push(p1, 0, 0, 0, 8'h00, p1, 0);
        if (op == 8'h18) m_c = 0;
        if (op == 8'h38) m_c = 1;
        if (op == 8'hE8) begin m_x = 8'((int'(m_x) + 1) % 256); set_nz(m_x); end
        if (op == 8'hAA) begin m_x = m_acc; set_nz(m_x); end
        m_pc = p1;
      end
      8'hA9, 8'hA2, 8'h69: begin
        push(p1, 0, 0, 0, 8'h00, p1, 0);
        if (op == 8'hA9) begin m_acc = imm; set_nz(imm); end
        if (op == 8'hA2) begin m_x = imm; set_nz(imm); end
        if (op == 8'h69) begin
          s  = int'(m_acc) + int'(imm) + int'(m_c);
          sa = (m_acc > 127) ? int'(m_acc) - 256 : int'(m_acc);
          si = (imm > 127) ? int'(imm) - 256 : int'(imm);
          m_v = (sa + si + int'(m_c) > 127) || (sa + si + int'(m_c) < -128);
          m_c = (s > 255);
          m_acc = 8'(s % 256);
          set_nz(m_acc);
        end
        m_pc = p2;
      end
      8'h4C: begin
        push(p1, 0, 0, 0, 8'h00, p1, 0);
        push(p2, 0, 0, 0, 8'h00, p2, 0);
        m_pc = {mmem[p2], imm};
      end
      8'h8D: begin
        t = {mmem[p2], imm};
        push(p1, 0, 0, 0, 8'h00, p1, 0);
        push(p2, 0, 0, 0, 8'h00, p2, 0);
        push(t, 0, 1, 0, m_acc, p2 + 16'd1, 0);
        m_pc = p2 + 16'd1;
      end
      default: begin
        m_halt = 1;
        m_pc = p1;
      end
    endcase
  endtask

  always @(negedge clk) begin : cmp
    cyc_t e;
    if (!rst_n) begin
      chk("rst_we", bus.we, 0);
      model_reset();
    end else begin
      if (q.size() == 0) model_step();
      e = q.pop_front();
      chk("cyc_addr", bus.addr, e.addr);
      chk("cyc_sync", bus.sync, e.sync);
      chk("cyc_we", bus.we, e.we);
      chk("cyc_dout", bus.data_out, e.dout);
      chk("cyc_halt", halted, e.hlt);
      chk("cyc_pc", pc, e.pc);
      if (e.we) mmem[e.addr] = e.dout;
      if (e.regs) begin
        chk("cyc_acc", acc, e.acc);
        chk("cyc_x", x, e.x);
        chk("cyc_st", st, e.st);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] tr_addr [0:31];
  logic [15:0] tr_pc   [0:31];
  logic        tr_sync [0:31];
  logic        tr_we   [0:31];
  logic        tr_halt [0:31];
  logic [7:0]  tr_dout [0:31];
  logic [7:0]  tr_acc  [0:31];
  logic [7:0]  tr_x    [0:31];
  logic [7:0]  tr_st   [0:31];
  logic [15:0] tr2_addr [0:31];
  logic [15:0] tr2_pc   [0:31];
  logic        tr2_sync [0:31];
  logic        tr2_halt [0:31];
  logic [7:0]  tr2_acc  [0:31];

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a]  = d;
    mmem[a] = d;
  endtask

  task automatic clear_mem();
    for (int a = 'h0200; a < 'h0400; a++) poke(16'(a), 8'h02);
    for (int a = 'h8000; a < 'h8100; a++) poke(16'(a), 8'h00);
    poke(16'h1234, 8'h00);
  endtask

  task automatic load(input logic [7:0] b [], input int n);
    for (int i = 0; i < n; i++) poke(16'h0200 + 16'(i), b[i]);
  endtask

  task automatic reset_assert();
    @(posedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_addr[i] = bus.addr;  tr_pc[i] = pc;    tr_sync[i] = bus.sync;
      tr_we[i]   = bus.we;    tr_halt[i] = halted;
      tr_dout[i] = bus.data_out;
      tr_acc[i]  = acc;       tr_x[i] = x;      tr_st[i] = st;
      tr2_addr[i] = bus2.addr; tr2_pc[i] = pc2; tr2_sync[i] = bus2.sync;
      tr2_halt[i] = halted2;   tr2_acc[i] = acc2;
    end
  endtask

  task automatic gen_random();
    logic [15:0] a, t;
    logic [15:0] starts [0:63];
    int          nins, r;
    a = 16'h0200;
    nins = $urandom_range(8, 40);
    for (int k = 0; k < nins; k++) begin
      starts[k] = a;
      r = $urandom_range(0, 19);
      if (r <= 2) begin
        poke(a, 8'hA9); poke(a + 1, 8'($urandom_range(0, 255))); a += 2;
      end else if (r <= 4) begin
        poke(a, 8'hA2); poke(a + 1, 8'($urandom_range(0, 255))); a += 2;
      end else if (r <= 7) begin
        poke(a, 8'h69); poke(a + 1, 8'($urandom_range(0, 255))); a += 2;
      end else if (r == 8) begin
        poke(a, 8'h18); a += 1;
      end else if (r == 9) begin
        poke(a, 8'h38); a += 1;
      end else if (r <= 11) begin
        poke(a, 8'hE8); a += 1;
      end else if (r == 12) begin
        poke(a, 8'hAA); a += 1;
      end else if (r == 13) begin
        poke(a, 8'hEA); a += 1;
      end else if (r <= 16) begin
        poke(a, 8'h8D); poke(a + 1, 8'($urandom_range(0, 255)));
        poke(a + 2, 8'h80); a += 3;
      end else if (r <= 18) begin
        t = a + 16'd4;
        poke(a, 8'h4C); poke(a + 1, t[7:0]); poke(a + 2, t[15:8]);
        poke(a + 3, 8'($urandom_range(0, 255))); a += 4;
      end else begin
        t = starts[$urandom_range(0, k)];
        poke(a, 8'h4C); poke(a + 1, t[7:0]); poke(a + 2, t[15:8]); a += 3;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] p1 [] = '{8'hA9, 8'h7F, 8'h69, 8'h01};
    logic [7:0] p2 [] = '{8'h38, 8'hA9, 8'hFF, 8'h69, 8'h00};
    logic [7:0] p3 [] = '{8'hA9, 8'h5A, 8'h8D, 8'h34, 8'h12};
    logic [7:0] p4 [] = '{8'hA2, 8'hFF, 8'hE8, 8'h4C, 8'h00, 8'h02};
    logic [4:0] sync_pat;
    int         wcnt, mism;
    bit         found;

    rst_n = 1'b0;
    model_reset();

    // LDA/ADC overflow into sign bit; second core starts at FFFF
    reset_assert();
    clear_mem(); load(p1, 4);
    mem2[16'hFFFF] = 8'hA9; mem2[16'h0000] = 8'h42; mem2[16'h0001] = 8'h02;
    reset_release();
    run(8);
    chk("t1_rst_addr", tr_addr[0], 16'h0200);
    chk("t1_rst_sync", tr_sync[0], 1);
    chk("t1_rst_acc", tr_acc[0], 0);
    chk("t1_rst_x", tr_x[0], 0);
    chk("t1_rst_st", tr_st[0], 0);
    sync_pat = 5'b10101;
    for (int i = 0; i < 5; i++) chk("t1_sync", tr_sync[i], sync_pat[4 - i]);
    chk("t1_acc", tr_acc[5], 8'h80);
    chk("t1_st", tr_st[5], 8'hC0);
    chk("t1_halt", tr_halt[5], 1);
    chk("t1w_addr0", tr2_addr[0], 16'hFFFF);
    chk("t1w_sync0", tr2_sync[0], 1);
    chk("t1w_addr1", tr2_addr[1], 16'h0000);
    chk("t1w_pc1", tr2_pc[1], 16'h0000);
    chk("t1w_halt", tr2_halt[3], 1);
    chk("t1w_acc", tr2_acc[3], 8'h42);
    chk("t1w_pc", tr2_pc[3], 16'h0002);

    // SEC dummy read, carry-in wraps sum to zero
    reset_assert();
    clear_mem(); load(p2, 5);
    reset_release();
    run(8);
    chk("t2_dummy_addr", tr_addr[1], 16'h0201);
    chk("t2_dummy_pc", tr_pc[1], 16'h0201);
    chk("t2_pc_hold", tr_pc[2], 16'h0201);
    chk("t2_acc", tr_acc[7], 8'h00);
    chk("t2_st", tr_st[7], 8'h03);

    // STA absolute
    reset_assert();
    clear_mem(); load(p3, 5);
    reset_release();
    run(10);
    chk("t3_wr_addr", tr_addr[5], 16'h1234);
    chk("t3_wr_we", tr_we[5], 1);
    chk("t3_wr_dout", tr_dout[5], 8'h5A);
    wcnt = 0;
    for (int i = 0; i < 10; i++) if (tr_we[i]) wcnt++;
    chk("t3_we_count", wcnt, 1);
    chk("t3_next_fetch", tr_addr[6], 16'h0205);
    chk("t3_mem", mem[16'h1234], 8'h5A);

    // LDX/INX wrap and JMP back
    reset_assert();
    clear_mem(); load(p4, 6);
    reset_release();
    run(10);
    chk("t4_st_ldx", tr_st[2], 8'h80);
    chk("t4_jmp_fetch", tr_addr[4], 16'h0203);
    chk("t4_loop_addr", tr_addr[7], 16'h0200);
    chk("t4_loop_sync", tr_sync[7], 1);
    chk("t4_x", tr_x[7], 8'h00);
    chk("t4_st", tr_st[7], 8'h02);

    // unknown opcode halts
    reset_assert();
    clear_mem();
    reset_release();
    run(22);
    chk("t5_pc", tr_pc[1], 16'h0201);
    for (int i = 1; i <= 20; i++) begin
      chk("t5_halt", tr_halt[i], 1);
      chk("t5_sync", tr_sync[i], 0);
      chk("t5_we", tr_we[i], 0);
    end

    // reset during the WRITE cycle drops the store
    reset_assert();
    clear_mem(); load(p3, 5); poke(16'h1234, 8'hEE);
    reset_release();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2 found = bus.we;
    end
    chk("t6_we_seen", found, 1);
    rst_n = 1'b0;
    #1 chk("t6_we_gated", bus.we, 0);
    reset_release();
    run(3);
    chk("t6_mem", mem[16'h1234], 8'hEE);
    chk("t6_addr", tr_addr[0], 16'h0200);
    chk("t6_sync", tr_sync[0], 1);
    chk("t6_acc", tr_acc[0], 8'h00);

    // random programs with occasional reset pulses
    for (int p = 0; p < 25; p++) begin
      reset_assert();
      clear_mem();
      gen_random();
      reset_release();
      for (int c = 0; c < 150; c++) begin
        @(posedge clk);
        #2 rst_n = ($urandom_range(0, 79) != 0);
      end
      mism = 0;
      for (int a = 'h8000; a < 'h8100; a++) if (mem[a] !== mmem[a]) mism++;
      chk("rnd_store_mem", mism, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
